// File: rtl/fitness_sorter_if.sv
// fitness_sorter_if: RAM request/acknowledge bus between the fitness sorter
// (master) and the genome DNA memory (slave).
//   ram_req   master->slave  access request, held until ram_ack
//   ram_we    master->slave  1 = write, 0 = read
//   ram_addr  master->slave  word address
//   ram_wdata master->slave  write data
//   ram_ack   slave->master  one-cycle access-complete pulse
//   ram_rdata slave->master  read data, valid in the ram_ack cycle
interface fitness_sorter_if #(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned GENE_W = 16
);
    logic              ram_req;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [GENE_W-1:0] ram_wdata;
    logic              ram_ack;
    logic [GENE_W-1:0] ram_rdata;

    modport master (
        output ram_req, ram_we, ram_addr, ram_wdata,
        input  ram_ack, ram_rdata
    );

    modport slave (
        input  ram_req, ram_we, ram_addr, ram_wdata,
        output ram_ack, ram_rdata
    );
endinterface

// File: rtl/fitness_sorter.sv
// fitness_sorter: ranks NETWORKS genomes by fitness (descending, stable
// bubble sort) and mirrors every fitness swap by swapping the two DNA
// records in external RAM, so slot i ends up holding the i-th best network.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   fit_we/idx/data   fitness table load, accepted only while idle
//   start             single-cycle pulse that begins a sort
//   busy              sort in progress
//   done              one-cycle pulse at sort completion
//   best_fit          fitness table entry 0
//   ram               RAM req/ack bus (master side)
//
// Optional build macro FITNESS_SORT_EARLY_EXIT_EN: finish as soon as a whole
// pass completes without a swap instead of always running NETWORKS-1 passes.
module fitness_sorter #(
    parameter int unsigned NETWORKS  = 16,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned FIT_W     = 16,
    parameter int unsigned GENE_W    = 16,
    parameter int unsigned DNA_LEN   = 11,
    parameter int unsigned ADDR_W    = 23,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fit_we,
    input  logic [IDX_W-1:0]   fit_idx,
    input  logic [FIT_W-1:0]   fit_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [FIT_W-1:0]   best_fit,
    fitness_sorter_if.master   ram
);

    localparam int unsigned GCNT_W = (DNA_LEN > 1) ? $clog2(DNA_LEN) : 1;
    localparam logic [IDX_W:0] NET_CNT = (IDX_W+1)'(NETWORKS);

    typedef enum logic [2:0] {
        IDLE,
        CMP,
        RD_A,
        RD_B,
        WR_A,
        WR_B,
        DONE
    } stateType;

    stateType          state;
    logic [FIT_W-1:0]  fitTable [NETWORKS];
    logic [GENE_W-1:0] bufA [DNA_LEN];
    logic [GENE_W-1:0] bufB [DNA_LEN];
    logic [IDX_W-1:0]  idx;
    logic [IDX_W:0]    pass;
    logic [GCNT_W-1:0] gene;
`ifdef FITNESS_SORT_EARLY_EXIT_EN
    logic              passSwapped;
`endif

    logic [IDX_W-1:0]  idxNext;
    logic              lastPair;
    logic              sortEnd;
    logic              doSwap;
    logic              lastGene;
    logic              advance;
    logic              isWrite;
    logic [IDX_W-1:0]  netSel;
    logic [ADDR_W-1:0] geneAddr;
    logic [GENE_W-1:0] geneWdata;

    assign best_fit = fitTable[0];

    always_comb begin
        idxNext  = idx + 1'b1;
        lastPair = (idx == IDX_W'(NETWORKS - 2));
        sortEnd  = (pass == (IDX_W+1)'(NETWORKS - 2));
`ifdef FITNESS_SORT_EARLY_EXIT_EN
        sortEnd  = sortEnd || !passSwapped;
`endif
        // Strict less-than keeps equal fitnesses in place (stable sort).
        doSwap   = (fitTable[idx] < fitTable[idxNext]);
        lastGene = (gene == GCNT_W'(DNA_LEN - 1));
        isWrite  = (state == WR_A) || (state == WR_B);
        netSel   = ((state == RD_B) || (state == WR_B)) ? idxNext : idx;
        geneAddr = ADDR_W'(BASE_ADDR) + ADDR_W'(netSel) * ADDR_W'(DNA_LEN)
                 + ADDR_W'(gene);
        // Network i receives B's DNA, network i+1 receives A's.
        geneWdata = (state == WR_A) ? bufB[gene] : bufA[gene];
        // The index advance happens either straight from a non-swapping
        // compare or after the final write of a DNA swap.
        advance  = ((state == CMP) && !doSwap)
                || ((state == WR_B) && ram.ram_req && ram.ram_ack && lastGene);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            ram.ram_req   <= 1'b0;
            ram.ram_we    <= 1'b0;
            ram.ram_addr  <= '0;
            ram.ram_wdata <= '0;
            idx           <= '0;
            pass          <= '0;
            gene          <= '0;
`ifdef FITNESS_SORT_EARLY_EXIT_EN
            passSwapped   <= 1'b0;
`endif
            for (int unsigned k = 0; k < NETWORKS; k++) fitTable[k] <= '0;
            for (int unsigned k = 0; k < DNA_LEN; k++) begin
                bufA[k] <= '0;
                bufB[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fit_we && ({1'b0, fit_idx} < NET_CNT))
                        fitTable[fit_idx] <= fit_data;
                    if (start) begin
                        busy  <= 1'b1;
                        pass  <= '0;
                        idx   <= '0;
`ifdef FITNESS_SORT_EARLY_EXIT_EN
                        passSwapped <= 1'b0;
`endif
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (doSwap) begin
                        fitTable[idx]     <= fitTable[idxNext];
                        fitTable[idxNext] <= fitTable[idx];
`ifdef FITNESS_SORT_EARLY_EXIT_EN
                        passSwapped <= 1'b1;
`endif
                        gene  <= '0;
                        state <= RD_A;
                    end
                end
                RD_A, RD_B, WR_A, WR_B: begin
                    // ram_req low here guarantees the idle cycle between
                    // accesses; an ack seen while req is low is ignored.
                    if (!ram.ram_req) begin
                        ram.ram_req  <= 1'b1;
                        ram.ram_we   <= isWrite;
                        ram.ram_addr <= geneAddr;
                        if (isWrite) ram.ram_wdata <= geneWdata;
                    end else if (ram.ram_ack) begin
                        ram.ram_req <= 1'b0;
                        if (state == RD_A) bufA[gene] <= ram.ram_rdata;
                        if (state == RD_B) bufB[gene] <= ram.ram_rdata;
                        if (lastGene) begin
                            gene <= '0;
                            case (state)
                                RD_A:    state <= RD_B;
                                RD_B:    state <= WR_A;
                                WR_A:    state <= WR_B;
                                default: state <= CMP;
                            endcase
                        end else begin
                            gene <= gene + 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (advance) begin
                if (lastPair) begin
                    idx  <= '0;
                    pass <= pass + 1'b1;
`ifdef FITNESS_SORT_EARLY_EXIT_EN
                    passSwapped <= 1'b0;
`endif
                    if (sortEnd) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= CMP;
                    end
                end else begin
                    idx   <= idxNext;
                    state <= CMP;
                end
            end
        end
    end

endmodule
